// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions between the issue stage and the ALU.
//   - alu_op_e : 5-bit ALU operation code carried on trans_instruct
//   - OP_R / OP_I : RV32I opcodes for register and immediate ALU forms
//   - F3_* : funct3 field values
//   - decode_op : funct3 + alternate bit (instr[30]) -> ALU operation
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_NOP  = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_AND  = 5'd3,
    ALU_OR   = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SLL  = 5'd6,
    ALU_SRL  = 5'd7,
    ALU_SRA  = 5'd8,
    ALU_SLT  = 5'd9,
    ALU_SLTU = 5'd10
  } alu_op_e;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // alt selects SUB over ADD and SRA over SRL; the caller decides whether
  // the alternate form is legal for the instruction format.
  function automatic alu_op_e decode_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x XLEN register file, x0 reads as zero.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears array)
//   we, waddr, wdata    synchronous write port (writes to x0 ignored)
//   raddr_a / rdata_a   combinational read port A
//   raddr_b / rdata_b   combinational read port B
// A read of the address being written on the same edge returns the old value.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I R/I-type ALU instructions, supplies registered
// operands and op code to the ALU, and writes the ALU result back.
// Optional build macro: ALU_ISSUE_FWD_EN (forward alu_rd_i to a source that
// matches the slot B destination instead of stalling on it).
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   instr_valid_i, instr_i    instruction offer
//   instr_ready_o             combinational accept indication
//   dmem_rs1_o, dmem_rs2_o    registered ALU operands A/B
//   trans_instruct_o          registered ALU op code (alu_op_e)
//   alu_rd_i                  ALU result, valid the cycle after the ALU edge
//   wb_valid_o/addr_o/data_o  register-file write for this cycle
//   illegal_o                 one-cycle pulse for an accepted unsupported opcode
//
// Handshake: an instruction transfers on a rising edge where
// instr_valid_i && instr_ready_o. instr_ready_o depends only on instr_i and
// the pending-destination slots, never on instr_valid_i; the producer must
// hold instr_i stable while instr_valid_i is high and not yet accepted.
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_i,
  output logic            instr_ready_o,
  output logic [XLEN-1:0] dmem_rs1_o,
  output logic [XLEN-1:0] dmem_rs2_o,
  output logic [4:0]      trans_instruct_o,
  input  logic [XLEN-1:0] alu_rd_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_addr_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            illegal_o
);

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [11:0] imm;
  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign imm    = instr_i[31:20];

  logic is_r, is_i, is_legal;
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_legal = is_r | is_i;

  // Destinations in flight; 0 means empty (x0 never creates a hazard).
  logic [4:0] slot_a, slot_b;

  logic [XLEN-1:0] rf_a, rf_b;

  alu_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk     (clk_i),
    .rst     (rst_i),
    .we      (wb_valid_o),
    .waddr   (wb_addr_o),
    .wdata   (wb_data_o),
    .raddr_a (rs1),
    .rdata_a (rf_a),
    .raddr_b (rs2),
    .rdata_b (rf_b)
  );

  logic hit_a_rs1, hit_a_rs2, hit_b_rs1, hit_b_rs2;
  assign hit_a_rs1 = is_legal && (slot_a != 5'd0) && (rs1 == slot_a);
  assign hit_a_rs2 = is_r     && (slot_a != 5'd0) && (rs2 == slot_a);
  assign hit_b_rs1 = is_legal && (slot_b != 5'd0) && (rs1 == slot_b);
  assign hit_b_rs2 = is_r     && (slot_b != 5'd0) && (rs2 == slot_b);

  // Slot B's result is on alu_rd_i this cycle but only reaches the array at
  // the next edge, so the array read would be stale.
  logic [XLEN-1:0] src_a, src_b;
`ifdef ALU_ISSUE_FWD_EN
  assign instr_ready_o = !rst_i && !(hit_a_rs1 || hit_a_rs2);
  assign src_a = hit_b_rs1 ? alu_rd_i : rf_a;
  assign src_b = hit_b_rs2 ? alu_rd_i : rf_b;
`else
  assign instr_ready_o = !rst_i && !(hit_a_rs1 || hit_a_rs2 || hit_b_rs1 || hit_b_rs2);
  assign src_a = rf_a;
  assign src_b = rf_b;
`endif

  logic accept;
  assign accept = instr_valid_i && instr_ready_o;

  // instr[30] is the alternate bit: SUB/SRA for R-type, SRAI only for I-type.
  alu_op_e dec_op;
  logic [XLEN-1:0] opnd_b;
  always_comb begin
    dec_op = ALU_NOP;
    opnd_b = src_b;
    if (is_r) begin
      dec_op = decode_op(funct3, instr_i[30]);
    end else if (is_i) begin
      dec_op = decode_op(funct3, (funct3 == F3_SRL_SRA) && instr_i[30]);
      if ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA)) begin
        opnd_b = {{(XLEN-5){1'b0}}, imm[4:0]};
      end else begin
        opnd_b = {{(XLEN-12){imm[11]}}, imm};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmem_rs1_o       <= '0;
      dmem_rs2_o       <= '0;
      trans_instruct_o <= ALU_NOP;
      illegal_o        <= 1'b0;
      slot_a           <= 5'd0;
      slot_b           <= 5'd0;
    end else begin
      // Default: bubble into slot A, NOP to the ALU, operands held.
      slot_b           <= slot_a;
      slot_a           <= 5'd0;
      trans_instruct_o <= ALU_NOP;
      illegal_o        <= 1'b0;
      if (accept) begin
        if (is_legal) begin
          dmem_rs1_o       <= src_a;
          dmem_rs2_o       <= opnd_b;
          trans_instruct_o <= dec_op;
          slot_a           <= rd;
        end else begin
          illegal_o <= 1'b1;
        end
      end
    end
  end

  assign wb_valid_o = (slot_b != 5'd0);
  assign wb_addr_o  = slot_b;
  assign wb_data_o  = wb_valid_o ? alu_rd_i : '0;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue with a small registered ALU
// model feeding alu_rd_i. Writebacks are checked against an expected queue.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] dmem_rs1, dmem_rs2;
  logic [4:0]  trans_instruct;
  logic [31:0] alu_rd;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;

  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];  // {addr, data}

  alu_issue dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .instr_valid_i    (instr_valid),
    .instr_i          (instr),
    .instr_ready_o    (instr_ready),
    .dmem_rs1_o       (dmem_rs1),
    .dmem_rs2_o       (dmem_rs2),
    .trans_instruct_o (trans_instruct),
    .alu_rd_i         (alu_rd),
    .wb_valid_o       (wb_valid),
    .wb_addr_o        (wb_addr),
    .wb_data_o        (wb_data),
    .illegal_o        (illegal)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Reference ALU: registers its result one edge after operands appear.
  function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      5'd1:    return a + b;
      5'd2:    return a - b;
      5'd3:    return a & b;
      5'd4:    return a | b;
      5'd5:    return a ^ b;
      5'd6:    return a << b[4:0];
      5'd7:    return a >> b[4:0];
      5'd8:    return $unsigned($signed(a) >>> b[4:0]);
      5'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd10:   return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) alu_rd <= 32'd0;
    else     alu_rd <= alu_model(trans_instruct, dmem_rs1, dmem_rs2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every writeback must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected_addr", {27'd0, wb_addr}, 32'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wb_addr", {27'd0, wb_addr}, {27'd0, e[36:32]});
        check("wb_data", wb_data, e[31:0]);
      end
    end
  end

  // instruction encoders
  function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // driver: called just after a negedge; returns just after the negedge
  // following the accepting edge, with instr_valid dropped.
  task automatic send(input logic [31:0] ins, input logic [4:0] erd,
                      input logic [31:0] edata, output int stalls);
    stalls = 0;
    instr_valid = 1'b1;
    instr = ins;
    #1;
    while (!instr_ready && stalls < 10) begin
      @(negedge clk);
      stalls++;
      #1;
    end
    if (!instr_ready) begin
      check("send_timeout", 32'd1, 32'd0);
      instr_valid = 1'b0;
      return;
    end
    if (erd != 5'd0) exp_q.push_back({erd, edata});
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int st;
    int exp_stall;
    rst = 1'b1;
    instr_valid = 1'b1;
    instr = enc_i(3'b000, 5'd5, 5'd0, 12'd9);
    alu_rd = 32'd0;

    // reset held 2 cycles with a valid instruction offered
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rs1", dmem_rs1, 32'd0);
    check("rst_rs2", dmem_rs2, 32'd0);
    check("rst_op", {27'd0, trans_instruct}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0;
    instr_valid = 1'b0;
    idle(3);
    check("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("post_rst_op", {27'd0, trans_instruct}, 32'd0);

    // ADDI x1,x0,5
    send(enc_i(3'b000, 5'd1, 5'd0, 12'd5), 5'd1, 32'd5, st);
    check("addi_rs1", dmem_rs1, 32'd0);
    check("addi_rs2", dmem_rs2, 32'd5);
    check("addi_op", {27'd0, trans_instruct}, 32'd1);
    check("addi_no_wb_yet", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check("addi_wb_valid", {31'd0, wb_valid}, 32'd1);
    check("addi_wb_addr", {27'd0, wb_addr}, 32'd1);
    check("addi_wb_data", wb_data, 32'd5);
    check("addi_then_nop", {27'd0, trans_instruct}, 32'd0);
    idle(2);

    // RAW hazard: ADDI x6,x0,5 then ADD x2,x6,x6
`ifdef ALU_ISSUE_FWD_EN
    exp_stall = 1;
`else
    exp_stall = 2;
`endif
    send(enc_i(3'b000, 5'd6, 5'd0, 12'd5), 5'd6, 32'd5, st);
    send(enc_r(7'b0000000, 3'b000, 5'd2, 5'd6, 5'd6), 5'd2, 32'd10, st);
    check("raw_stalls", st, exp_stall);
    check("raw_rs1", dmem_rs1, 32'd5);
    check("raw_rs2", dmem_rs2, 32'd5);
    check("raw_op", {27'd0, trans_instruct}, 32'd1);
    idle(3);

    // x0 destination and sources
    send(enc_i(3'b000, 5'd0, 5'd0, 12'd7), 5'd0, 32'd0, st);
    send(enc_r(7'b0000000, 3'b000, 5'd3, 5'd0, 5'd0), 5'd3, 32'd0, st);
    check("x0_stalls", st, 0);
    check("x0_rs1", dmem_rs1, 32'd0);
    check("x0_rs2", dmem_rs2, 32'd0);
    idle(3);

    // unsupported opcode (load), then immediate next instruction
    send(32'h0000_2083, 5'd0, 32'd0, st);
    check("ill_pulse", {31'd0, illegal}, 32'd1);
    check("ill_op", {27'd0, trans_instruct}, 32'd0);
    send(enc_i(3'b000, 5'd5, 5'd0, 12'hFFD), 5'd5, 32'hFFFF_FFFD, st);
    check("ill_next_stalls", st, 0);
    check("ill_pulse_end", {31'd0, illegal}, 32'd0);
    check("ill_next_op", {27'd0, trans_instruct}, 32'd1);
    check("ill_next_rs2", dmem_rs2, 32'hFFFF_FFFD);

    // SUB x8,x1,x5 (depends on x5), then idle hold check
    send(enc_r(7'b0100000, 3'b000, 5'd8, 5'd1, 5'd5), 5'd8, 32'd8, st);
    check("sub_op", {27'd0, trans_instruct}, 32'd2);
    check("sub_rs1", dmem_rs1, 32'd5);
    check("sub_rs2", dmem_rs2, 32'hFFFF_FFFD);
    @(negedge clk);
    check("hold_op_nop", {27'd0, trans_instruct}, 32'd0);
    check("hold_rs1", dmem_rs1, 32'd5);
    check("hold_rs2", dmem_rs2, 32'hFFFF_FFFD);

    // SRAI x9,x5,1: shamt only on operand B
    send(enc_i(3'b101, 5'd9, 5'd5, 12'h401), 5'd9, 32'hFFFF_FFFE, st);
    check("srai_op", {27'd0, trans_instruct}, 32'd8);
    check("srai_rs2", dmem_rs2, 32'd1);
    send(enc_r(7'b0000000, 3'b011, 5'd10, 5'd1, 5'd5), 5'd10, 32'd1, st);
    check("sltu_op", {27'd0, trans_instruct}, 32'd10);
    send(enc_r(7'b0000000, 3'b010, 5'd11, 5'd1, 5'd5), 5'd11, 32'd0, st);
    check("slt_op", {27'd0, trans_instruct}, 32'd9);
    send(enc_i(3'b100, 5'd12, 5'd1, 12'hFFF), 5'd12, 32'hFFFF_FFFA, st);
    check("xori_op", {27'd0, trans_instruct}, 32'd5);
    check("xori_rs2", dmem_rs2, 32'hFFFF_FFFF);
    idle(4);

    // reset the cycle after accepting ADDI x4,x0,9: its writeback is lost
    send(enc_i(3'b000, 5'd4, 5'd0, 12'd9), 5'd0, 32'd0, st);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_wb_valid", {31'd0, wb_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_wb_valid2", {31'd0, wb_valid}, 32'd0);
    idle(2);
    send(enc_r(7'b0000000, 3'b000, 5'd7, 5'd4, 5'd0), 5'd7, 32'd0, st);
    check("rstmid_x4_zero", dmem_rs1, 32'd0);
    idle(4);

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Operand-supply and writeback end of the ALU interface. Decodes RV32I R-type and I-type ALU instructions, reads the 32x32 register file and drives dmem_rs1/dmem_rs2/trans_instruct to the ALU.
- Captures the registered alu_rd result and writes it back to the register file.
- Tracks in-flight destinations and stalls the instruction handshake on read-after-write hazards.

Parameters:
- XLEN, 32, datapath width
- NREG, 32, register count; x0 is hardwired to zero

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- instr_valid_i  in  1  instruction presented
- instr_i  in  32  RV32 instruction word
- instr_ready_o  out  1  instruction accepted on an edge where valid&&ready
- dmem_rs1_o  out  XLEN  ALU operand A (registered)
- dmem_rs2_o  out  XLEN  ALU operand B: rs2 value or sign-extended imm (registered)
- trans_instruct_o  out  5  ALU op code (registered)
- alu_rd_i  in  XLEN  ALU result, valid one cycle after the ALU captures its operands
- wb_valid_o  out  1  register-file write this cycle
- wb_addr_o  out  5  writeback destination
- wb_data_o  out  XLEN  writeback data
- illegal_o  out  1  one-cycle pulse when an unsupported opcode is accepted

Behaviour:
- Reset:
  - Register file, all outputs and both pending slots are cleared to 0.
  - trans_instruct_o=NOP (0).
  - A reset mid-operation discards any in-flight writeback.
- Decode:
  - opcode 0110011 (R-type): funct3/funct7 map to ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - opcode 0010011 (I-type): same mapping; SUB is not available; operand B = sign-extended imm[11:0]; shift amount = imm[4:0].
  - Any other opcode: op=NOP, no writeback, illegal_o pulses for 1 cycle.
- Pipeline timing, for an instruction accepted at edge E0:
  - E0: operand and op outputs update; the destination enters slot A.
  - E1: the ALU registers the result; slot A moves to slot B, and alu_rd_i is valid during the cycle after E1.
  - During the cycle after E1: wb_valid_o=1, wb_addr_o=B.rd, wb_data_o=alu_rd_i (combinational).
  - E2: array[B.rd] is written.
  - Throughput is 1 instruction per cycle when there is no hazard.
  - When nothing is accepted, outputs hold their values and op=NOP.
- x0:
  - Reads return 0.
  - Writes to rd=0 are suppressed (wb_valid_o=0).
  - rd=0 never creates a hazard.
- Hazard rule:
  - instr_ready_o=0 if a used source (rs1, or rs2 for R-type) equals a nonzero slot A rd.
  - It is also 0 if a used source equals a nonzero slot B rd, unless FWD_EN is defined.
  - Otherwise instr_ready_o=1.
  - A stall inserts NOP into slot A.
- Read during write: a source read in the same cycle as array write-back sees the old array value. The slot B check covers this case.
- Simultaneous accept and writeback:
  - Both happen on the same edge.
  - Slot B and slot A shift independently.

Optional Feature:
- Macro ALU_ISSUE_FWD_EN.
- Defined:
  - A source matching slot B rd is forwarded from alu_rd_i; no stall.
  - A slot A match still stalls.
  - A dependent instruction therefore incurs 1 stall cycle.
- Undefined:
  - A slot B match stalls.
  - A dependent instruction therefore incurs 2 stall cycles.

Decomposition:
- Package alu_pkg:
  - 5-bit op enum: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10.
  - Opcode constants OP_R=7'b0110011, OP_I=7'b0010011.
  - funct3 constants.
  - Shared with the ALU.
- Sub-module alu_regfile: 32xXLEN array, two combinational read ports, one synchronous write port, x0 forced to 0.

Test Plan:
- Reset: hold rst_i for 2 cycles with instr_valid_i=1 -> instr_ready_o has no effect, no writeback, trans_instruct_o=0, all outputs 0.
- ADDI x1,x0,5 -> dmem_rs1_o=0, dmem_rs2_o=5, trans_instruct_o=1. With the bench ALU returning 5, wb_valid_o=1, wb_addr_o=1, wb_data_o=5 two cycles after accept.
- ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back:
  - Without the macro: 2 stall cycles, then operands 5/5.
  - With ALU_ISSUE_FWD_EN: 1 stall cycle, and the operands are forwarded from alu_rd_i.
- ADDI x0,x0,7 then ADD x3,x0,x0 -> no stall, no writeback, operands 0/0.
- Opcode 0000011 (load) -> illegal_o pulses 1 cycle, op=NOP, no writeback, the next instruction is accepted the following cycle.
- Assert rst_i the cycle after accepting ADDI x4,x0,9 -> no writeback occurs; x4 reads 0 afterwards.
